// File: rtl/reduce_gate_pipe.sv
// -----------------------------------------------------------------------------
// reduce_gate_pipe
//
// Pipelined N-bit to 1-bit gate reduction. The operation is chosen for each
// transaction: AND, OR, XOR or NAND. The input is padded up to 2^LEVELS bits
// with the identity element of the chosen operation. The padded vector is then
// folded pairwise through LEVELS registered stages. Each stage has valid/ready
// flow control, and the stall signal ripples back through the stages, so a
// bubble is closed up even while the output is stalled.
//
// Parameters:
//   N      operand width, 2..64
//   CNT_W  width of the completed-transaction counter
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   R          synchronous active-high reset
//   A          operand vector (N bits)
//   MODE       operation: 00 AND, 01 OR, 10 XOR, 11 NAND
//   IN_VALID   A/MODE valid this cycle
//   IN_READY   block accepts A/MODE this cycle (combinational from OUT_READY)
//   Y          registered reduction result
//   OUT_VALID  Y valid
//   OUT_READY  downstream accepts Y
//   DONE_CNT   count of output transfers; wraps silently
// -----------------------------------------------------------------------------
module reduce_gate_pipe #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             R,
  input  logic [N-1:0]     A,
  input  logic [1:0]       MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             Y,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] DONE_CNT
);

  // Tree depth is fixed by N and is not a user parameter.
  localparam int LEVELS = $clog2(N);
  localparam int PAD_W  = 1 << LEVELS;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  logic [PAD_W-1:0]  padded;
  logic [LEVELS:1]   valid_vec;
  logic [LEVELS:1]   take;
  logic              chain_ready;

  // Fill the unused upper bits with the identity element, so the padding
  // does not change the result.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    padded = (op_e'(MODE) == OP_AND || op_e'(MODE) == OP_NAND) ? '1 : '0;
    padded[N-1:0] = A;
  end

  // Load condition for each stage. A stage loads when it is empty or when
  // its contents move on this edge. The chain starts from OUT_READY at the
  // last stage and ripples back to stage 1, which is how a bubble closes up.
  always_comb begin
    take        = '0;
    // NOTE: chain_ready is a combinational temporary carried across loop
    // iterations, so it must use blocking assignments; registers use <=.
    chain_ready = OUT_READY;
    for (int k = LEVELS; k >= 1; k--) begin
      take[k]     = !valid_vec[k] || chain_ready;
      chain_ready = take[k];
    end
  end

  assign IN_READY = take[1];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    localparam int W = PAD_W >> k;

    logic [W-1:0]   data;
    logic           valid;
    logic [2*W-1:0] src;
    logic [1:0]     src_mode;
    logic           src_valid;
    logic [W-1:0]   folded;

    if (k == 1) begin : g_src
      assign src       = padded;
      assign src_mode  = MODE;
      assign src_valid = IN_VALID;
    end else begin : g_src
      assign src       = g_stage[k-1].data;
      assign src_mode  = g_stage[k-1].g_mode.mode;
      assign src_valid = g_stage[k-1].valid;
    end

    // Fold adjacent bit pairs. NAND folds with AND. The final stage
    // inverts, so that the registered bit is already the output value.
    always_comb begin
      folded = '0;
      for (int i = 0; i < W; i++) begin
        case (op_e'(src_mode))
          OP_OR:   folded[i] = src[2*i] | src[2*i+1];
          OP_XOR:  folded[i] = src[2*i] ^ src[2*i+1];
          default: folded[i] = src[2*i] & src[2*i+1];
        endcase
      end
      if (k == LEVELS && op_e'(src_mode) == OP_NAND) begin
        folded = ~folded;
      end
    end

    // Data is captured only when the incoming slot is valid, so idle cycles
    // never disturb Y.
    always_ff @(posedge CLK) begin
      if (R) begin
        valid <= 1'b0;
        // NOTE: the data registers are reset too. This keeps Y at 0 after
        // reset, and stops any stale partial result from surviving it.
        data  <= '0;
      end else if (take[k]) begin
        valid <= src_valid;
        if (src_valid) begin
          data <= folded;
        end
      end
    end

    // The mode travels with the data up to the last stage, which no longer
    // needs it because the inversion is already applied.
    if (k < LEVELS) begin : g_mode
      logic [1:0] mode;
      always_ff @(posedge CLK) begin
        if (R) begin
          mode <= 2'b00;
        end else if (take[k] && src_valid) begin
          mode <= src_mode;
        end
      end
    end

    assign valid_vec[k] = valid;
  end

  assign Y         = g_stage[LEVELS].data[0];
  assign OUT_VALID = valid_vec[LEVELS];

  always_ff @(posedge CLK) begin
    if (R) begin
      DONE_CNT <= '0;
    end else if (OUT_VALID && OUT_READY) begin
      DONE_CNT <= DONE_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// -----------------------------------------------------------------------------
// tb_reduce_gate_pipe
//
// Directed bench for reduce_gate_pipe. Four instances share the same
// stimulus:
//   u8  N=8, CNT_W=16  main instance
//   u5  N=5            padding
//   u2  N=2            single stage
//   u4  N=8, CNT_W=4   counter wrap
// Inputs change 1 time unit after the rising edge, and outputs are sampled at
// the same point.
// -----------------------------------------------------------------------------
module tb_reduce_gate_pipe;

  logic       clk = 1'b0;
  logic       r;
  logic [7:0] a;
  logic [1:0] mode;
  logic       in_valid;
  logic       out_ready;

  logic        rdy8, y8, ov8;
  logic [15:0] cnt8;
  logic        rdy5, y5, ov5;
  logic [15:0] cnt5;
  logic        rdy2, y2, ov2;
  logic [15:0] cnt2;
  logic        rdy4, y4, ov4;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  // Vectors for stream(), with the expected Y worked out by hand.
  logic [7:0] sa [0:7];
  logic [1:0] sm [0:7];
  logic       sy [0:7];

  always #5 clk = ~clk;

  reduce_gate_pipe #(.N(8), .CNT_W(16)) u8 (
    .CLK(clk), .R(r), .A(a), .MODE(mode), .IN_VALID(in_valid),
    .IN_READY(rdy8), .Y(y8), .OUT_VALID(ov8), .OUT_READY(out_ready),
    .DONE_CNT(cnt8)
  );

  reduce_gate_pipe #(.N(5), .CNT_W(16)) u5 (
    .CLK(clk), .R(r), .A(a[4:0]), .MODE(mode), .IN_VALID(in_valid),
    .IN_READY(rdy5), .Y(y5), .OUT_VALID(ov5), .OUT_READY(out_ready),
    .DONE_CNT(cnt5)
  );

  reduce_gate_pipe #(.N(2), .CNT_W(16)) u2 (
    .CLK(clk), .R(r), .A(a[1:0]), .MODE(mode), .IN_VALID(in_valid),
    .IN_READY(rdy2), .Y(y2), .OUT_VALID(ov2), .OUT_READY(out_ready),
    .DONE_CNT(cnt2)
  );

  reduce_gate_pipe #(.N(8), .CNT_W(4)) u4 (
    .CLK(clk), .R(r), .A(a), .MODE(mode), .IN_VALID(in_valid),
    .IN_READY(rdy4), .Y(y4), .OUT_VALID(ov4), .OUT_READY(out_ready),
    .DONE_CNT(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    r        = 1'b1;
    next_edge();
    r        = 1'b0;
  endtask

  // Returns {OUT_VALID, Y} of the selected instance.
  function automatic logic [1:0] obs(input int sel);
    case (sel)
      8:       return {ov8, y8};
      5:       return {ov5, y5};
      2:       return {ov2, y2};
      default: return {ov4, y4};
    endcase
  endfunction

  // Sends n vectors back to back with OUT_READY held high. Each result must
  // appear exactly lat edges after the vector is driven, with no gaps between
  // results. The pipeline must be idle afterwards.
  task automatic stream(input int n, input int lat, input int sel,
                        input string tag);
    logic [1:0] o;
    out_ready = 1'b1;
    for (int c = 0; c < n + lat - 1; c++) begin
      if (c < n) begin
        a        = sa[c];
        mode     = sm[c];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      next_edge();
      if (c + 1 >= lat) begin
        o = obs(sel);
        check($sformatf("%s_out%0d", tag, c + 1 - lat), {30'd0, o},
              {30'd0, 1'b1, sy[c + 1 - lat]});
      end
    end
    in_valid = 1'b0;
    next_edge();
    o = obs(sel);
    check({tag, "_idle"}, {31'd0, o[1]}, 32'd0);
  endtask

  initial begin
    int  k;
    logic acc;

    r         = 1'b0;
    a         = '0;
    mode      = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    do_reset();
    check("rst_ov",   {31'd0, ov8},  32'd0);
    check("rst_y",    {31'd0, y8},   32'd0);
    check("rst_cnt",  {16'd0, cnt8}, 32'd0);
    check("rst_rdy",  {31'd0, rdy8}, 32'd1);

    // Basic reduction: FF AND -> 1, FE AND -> 0; two transfers counted.
    sa[0] = 8'hFF; sm[0] = 2'b00; sy[0] = 1'b1;
    sa[1] = 8'hFE; sm[1] = 2'b00; sy[1] = 1'b0;
    stream(2, 3, 8, "basic");
    check("basic_cnt", {16'd0, cnt8}, 32'd2);

    // Mixed modes back to back: 00 OR -> 0, 07 XOR -> 1, FF NAND -> 0.
    do_reset();
    sa[0] = 8'h00; sm[0] = 2'b01; sy[0] = 1'b0;
    sa[1] = 8'h07; sm[1] = 2'b10; sy[1] = 1'b1;
    sa[2] = 8'hFF; sm[2] = 2'b11; sy[2] = 1'b0;
    stream(3, 3, 8, "mixed");

    // Padding with N=5.
    do_reset();
    sa[0] = 8'h1F; sm[0] = 2'b00; sy[0] = 1'b1;  // pad 1: all ones
    sa[1] = 8'h1F; sm[1] = 2'b10; sy[1] = 1'b1;  // pad 0: five ones, odd
    sa[2] = 8'h00; sm[2] = 2'b11; sy[2] = 1'b1;  // pad 1: AND 0, inverted
    sa[3] = 8'h1E; sm[3] = 2'b00; sy[3] = 1'b0;
    sa[4] = 8'h15; sm[4] = 2'b10; sy[4] = 1'b1;  // three ones
    stream(5, 3, 5, "pad5");

    // N=2: a single stage with 1-cycle latency.
    do_reset();
    sa[0] = 8'h01; sm[0] = 2'b00; sy[0] = 1'b0;
    sa[1] = 8'h01; sm[1] = 2'b01; sy[1] = 1'b1;
    sa[2] = 8'h03; sm[2] = 2'b10; sy[2] = 1'b0;
    sa[3] = 8'h01; sm[3] = 2'b10; sy[3] = 1'b1;
    sa[4] = 8'h03; sm[4] = 2'b11; sy[4] = 1'b0;
    sa[5] = 8'h00; sm[5] = 2'b11; sy[5] = 1'b1;
    stream(6, 1, 2, "n2");

    // Backpressure: exactly three accepts fill the pipe, and Y is held.
    do_reset();
    sa[0] = 8'hFF; sm[0] = 2'b00;  // -> 1
    sa[1] = 8'h00; sm[1] = 2'b01;  // -> 0
    sa[2] = 8'h01; sm[2] = 2'b10;  // -> 1
    sa[3] = 8'hFF; sm[3] = 2'b11;  // -> 0
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      a        = sa[k];
      mode     = sm[k];
      in_valid = 1'b1;
      #1;
      check($sformatf("bp_rdy%0d", c), {31'd0, rdy8}, {31'd0, (c < 3)});
      acc = rdy8;
      next_edge();
      if (acc && k < 4) k++;
      if (c >= 2) begin
        check($sformatf("bp_hold%0d", c), {30'd0, ov8, y8}, 32'd3);
      end
    end
    check("bp_accepts", k, 32'd3);
    a         = sa[3];
    mode      = sm[3];
    out_ready = 1'b1;
    #1;
    check("bp_rdy_release", {31'd0, rdy8}, 32'd1);
    next_edge();
    in_valid = 1'b0;
    check("bp_r1", {30'd0, ov8, y8}, 32'd2);
    check("bp_c1", {16'd0, cnt8},    32'd1);
    next_edge();
    check("bp_r2", {30'd0, ov8, y8}, 32'd3);
    next_edge();
    check("bp_r3", {30'd0, ov8, y8}, 32'd2);
    next_edge();
    check("bp_drained", {31'd0, ov8}, 32'd0);
    check("bp_cnt",     {16'd0, cnt8}, 32'd4);

    // Reset mid-flight: one result at the output and two still in the pipe.
    a        = 8'hFF;
    mode     = 2'b00;
    in_valid = 1'b1;
    next_edge();
    next_edge();
    next_edge();
    in_valid = 1'b0;
    check("mid_pre_y", {30'd0, ov8, y8}, 32'd3);
    r = 1'b1;
    next_edge();
    r = 1'b0;
    check("mid_ov",  {31'd0, ov8},  32'd0);
    check("mid_y",   {31'd0, y8},   32'd0);
    check("mid_cnt", {16'd0, cnt8}, 32'd0);
    check("mid_rdy", {31'd0, rdy8}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      next_edge();
      check($sformatf("mid_stale%0d", c), {31'd0, ov8}, 32'd0);
    end

    // Counter wrap with CNT_W=4: 17 transfers.
    do_reset();
    out_ready = 1'b1;
    a         = 8'h55;
    mode      = 2'b10;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 17);
      next_edge();
      if (c + 1 == 18) check("wrap_15", {28'd0, cnt4}, 32'd15);
      if (c + 1 == 19) check("wrap_16", {28'd0, cnt4}, 32'd0);
      if (c + 1 == 20) begin
        check("wrap_17",    {28'd0, cnt4}, 32'd1);
        check("wide_17",    {16'd0, cnt8}, 32'd17);
      end
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reduce_gate_pipe.md
Name: reduce_gate_pipe

Overview:
- Parametrised, pipelined successor to the fixed 2-input AND cell.
- Reduces an N-bit input vector to one bit with a per-transaction selectable operation (AND, OR, XOR, NAND).
- Built as a registered tree of 2-input levels with valid/ready flow control.
- Used where wide gate reductions (parity, all-ones/any-ones detect) must meet timing at the library clock rate.

Parameters:
- N, 8: number of input bits reduced; legal range 2..64.
- LEVELS, ceil(log2(N)): tree depth and pipeline latency; derived, not to be overridden.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- R  in  1  reset; synchronous, active-high.
- A  in  N  operand vector.
- MODE  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- IN_VALID  in  1  A/MODE valid this cycle.
- IN_READY  out  1  block accepts A/MODE this cycle.
- Y  out  1  reduction result.
- OUT_VALID  out  1  Y valid.
- OUT_READY  in  1  downstream accepts Y.
- DONE_CNT  out  CNT_W  count of results consumed (OUT_VALID && OUT_READY).

Behaviour:
- Reset, with R high at a rising CLK edge:
  - All stage valid bits clear, so OUT_VALID=0.
  - Y=0 and DONE_CNT=0.
  - All stage data registers clear.
  - IN_READY=1 in the cycle after reset, because the pipeline is empty.
- Reset mid-operation discards every in-flight transaction. No partial result appears after reset.
- Padding: A is extended to 2^LEVELS bits with the identity element of the operation.
  - AND and NAND pad with 1.
  - OR and XOR pad with 0.
- Tree structure:
  - Stage k (k=1..LEVELS) holds a 2^(LEVELS-k)-bit partial vector, a 2-bit mode and a valid bit.
  - Each stage combines adjacent bit pairs of the previous stage.
  - AND and NAND combine pairs with AND; OR with OR; XOR with XOR.
  - MODE travels with its data, so different modes may be in flight at the same time.
- Output:
  - The final stage holds 1 bit; Y equals that bit, inverted when the stage's mode is 11.
  - Y, OUT_VALID and DONE_CNT are registered outputs.
  - Y holds its value while OUT_VALID=1 and OUT_READY=0.
- Latency: a transaction accepted at edge t presents OUT_VALID=1 after edge t+LEVELS when no backpressure occurs.
- Throughput: one transaction per cycle when OUT_READY=1 is held.
- Handshake:
  - A transfer occurs on any edge where VALID && READY.
  - Stage k loads when it is empty or stage k+1 loads or drains in the same cycle.
  - IN_READY is the load condition of stage 1.
  - The final stage drains when OUT_READY=1.
  - Bubbles collapse under backpressure: with OUT_READY=0, the pipeline fills to LEVELS entries before IN_READY drops.
  - IN_READY may depend combinationally on OUT_READY.
  - IN_VALID must not depend on IN_READY.
- Simultaneous events:
  - When a stage drains and refills in the same edge, the stage takes the new data and stays valid.
  - With the pipeline full and OUT_READY=1, IN_READY=1.
- DONE_CNT:
  - Increments by 1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 without flag or saturation.
- A and MODE are sampled only on accepted cycles. Values on other cycles are ignored.
- N=2 gives LEVELS=1, i.e. one registered AND/OR/XOR/NAND stage with a 1-cycle latency.

Test Plan:
1. Basic reduction, N=8, OUT_READY=1:
   - Drive A=8'hFF MODE=00 at edge 0, then A=8'hFE MODE=00 at edge 1.
   - Required: Y=1 after edge 3 and Y=0 after edge 4, both with OUT_VALID=1.
   - Required: DONE_CNT=2 after edge 5.
2. Mixed modes back-to-back:
   - Drive A=8'h00 MODE=01, then A=8'h07 MODE=10, then A=8'hFF MODE=11, with no gaps.
   - Required: consecutive outputs Y=0, 1, 0; no idle cycle between results.
3. Padding, N=5 (LEVELS=3):
   - Drive A=5'h1F MODE=00 -> Y=1.
   - Drive A=5'h1F MODE=10 -> Y=1.
   - Drive A=5'h00 MODE=11 -> Y=1.
4. Backpressure:
   - Hold OUT_READY=0 and drive IN_VALID=1 continuously.
   - Required: IN_READY falls after exactly 3 accepts (N=8).
   - Required: Y stays stable through the stall.
   - Raise OUT_READY: results emerge in order with none lost or duplicated; IN_READY rises in the same cycle.
5. Reset mid-flight:
   - Accept 2 transactions, then assert R for 1 cycle.
   - Required: OUT_VALID=0, Y=0, DONE_CNT=0, IN_READY=1 next cycle; no stale result ever appears.
6. Counter wrap, CNT_W=4:
   - Complete 17 transfers.
   - Required: DONE_CNT reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
